apb3_master_bridge: RTL and testbench
=====================================

Name: apb3_master_bridge

Overview:
- Upstream APB3 master stage. Converts a simple single-outstanding request/response interface into APB3 SETUP/ACCESS cycles.
- Drives the 16 one-hot slot selects and PENABLE. Consumes the already-muxed PRDATA/PREADY/PSLVERR returned by the slot read-mux.
- Adds slot-enable masking and a transfer timeout, so that a hung slave cannot stall the CPU side.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and PADDR.
- SLOT_LSB, 24. Slot index is req_addr[SLOT_LSB+3:SLOT_LSB]. Legal range 0..ADDR_WIDTH-4.
- SLOT_EN, 16'hFFFF. Bit n=1 means slot n is present. Disabled slots error without a bus cycle.
- TIMEOUT, 255. Maximum number of ACCESS cycles with PREADY low. 0 disables the timeout.
- TO_WIDTH, 8. Width of the timeout counter. Must satisfy TIMEOUT < 2**TO_WIDTH.

Ports:
- PCLK  in  1  clock
- PRESETN  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bridge accepts a request this cycle
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  write data
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  read data (0 for writes and errors)
- resp_err  out  1  slave error, timeout, or disabled slot
- PADDR  out  ADDR_WIDTH  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PSELS  out  16  one-hot slot select
- PENABLE  out  1  APB access phase
- PRDATA  in  32  muxed read data
- PREADY  in  1  muxed ready
- PSLVERR  in  1  muxed error

Behaviour:
- Every output is a flop. At reset: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, PADDR=0, PWRITE=0, PWDATA=0, PSELS=0, PENABLE=0.
- States: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- req_ready=1 only in IDLE. The first cycle after reset deassertion is IDLE with req_ready=1.
- IDLE, on req_valid&&req_ready:
  - Latch req_addr, req_write and req_wdata into PADDR/PWRITE/PWDATA.
  - If SLOT_EN[slot]=0: go to RESP with resp_err=1, resp_rdata=0. PSELS stays 0.
  - Otherwise: set PSELS=1<<slot and go to SETUP.
- SETUP: lasts one cycle with PSEL high and PENABLE=0. Set PENABLE=1, clear the timeout counter, go to ACCESS.
- ACCESS, PREADY=1:
  - Capture resp_err=PSLVERR.
  - Capture resp_rdata=PRDATA if read and PSLVERR=0, else 0.
  - Clear PSELS and PENABLE, go to RESP.
- ACCESS, PREADY=0:
  - Counter increments.
  - If TIMEOUT!=0 and the counter equals TIMEOUT-1 in this cycle: abort. Clear PSELS/PENABLE, resp_err=1, resp_rdata=0, go to RESP.
  - PREADY=1 in the same cycle as the timeout boundary wins (normal completion).
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_err hold until the next response is formed.
- PADDR, PWRITE and PWDATA stay stable from SETUP through the last ACCESS cycle, and hold afterwards (no toggling in IDLE).
- Latency: acceptance at cycle N gives SETUP at N+1, first ACCESS at N+2, and resp_valid at N+3+w, where w is the number of wait states. A disabled slot gives resp_valid at N+1.
- Throughput: minimum 4 cycles per transfer.
- Read/write data width is fixed at 32. Slot index width is fixed at 4.
- Asynchronous reset mid-transfer: all outputs return to reset values immediately; no response is issued. The slave sees PSEL drop without completion, which is acceptable per system reset policy.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package apb3_pkg holds:
  - state enum (IDLE/SETUP/ACCESS/RESP)
  - NUM_SLOTS=16 and SLOT_IDX_W=4
  - helper function slot_onehot(idx)
- These are reused by the read-mux and the address decoder.
- One natural sub-module: apb3_timeout_cnt (clear, enable, terminal-count flag, parameterised TIMEOUT/TO_WIDTH). Everything else stays in one FSM file.

Test Plan:
- Read from slot 2, zero wait states. Req addr 0x0200_0010, PREADY=1, PRDATA=0xDEAD_BEEF -> PSELS=16'h0004 for 2 cycles, PENABLE high 1 cycle, resp_valid at N+3, resp_rdata=0xDEADBEEF, resp_err=0.
- Write to slot 15 with 3 wait states. Addr 0x0F00_0000, wdata 0x1234_5678 -> PWDATA/PADDR stable across 4 ACCESS cycles, resp_valid at N+6, resp_rdata=0, resp_err=0.
- Read to slot 5 with PREADY=1 and PSLVERR=1, PRDATA=0xFFFF_FFFF -> resp_err=1, resp_rdata=0.
- TIMEOUT=4, slave never ready -> exactly 4 ACCESS cycles, then PSELS=0, resp_err=1.
- Same setup with PREADY=1 on the 4th ACCESS cycle -> normal completion, resp_err=PSLVERR.
- SLOT_EN=16'h00FF, request to slot 9 -> PSELS never nonzero, resp_valid at N+1 with resp_err=1.
- Assert PRESETN low during ACCESS of a slot-3 read -> PSELS=0 and PENABLE=0 immediately, no resp_valid. After release, a new request completes normally.

Source files
------------

// File: rtl/apb3_pkg.sv
// Shared APB3 definitions for the bridge, the slot read-mux and the address
// decoder.
//   - apb_state_e  : bridge FSM states (IDLE/SETUP/ACCESS/RESP)
//   - NUM_SLOTS    : number of APB slots (16)
//   - SLOT_IDX_W   : width of a slot index (4)
//   - slot_onehot  : slot index -> one-hot PSEL vector
package apb3_pkg;

    localparam int NUM_SLOTS  = 16;
    localparam int SLOT_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_IDX_W-1:0] idx);
        logic [NUM_SLOTS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/apb3_timeout_cnt.sv
// ACCESS-phase wait-state counter for the APB3 bridge.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : restart the count at zero (has priority over en_i)
//   en_i          : count one wait state
//   tc_o          : the current count is the last permitted wait state
//                   (TIMEOUT-1); never asserted when TIMEOUT is 0
module apb3_timeout_cnt #(
    parameter int TIMEOUT  = 255,
    parameter int TO_WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    // TIMEOUT=0 disables the flag, so the compare value is irrelevant then.
    localparam logic [TO_WIDTH-1:0] TC_VAL = (TIMEOUT == 0) ? '0 : TO_WIDTH'(TIMEOUT - 1);

    logic [TO_WIDTH-1:0] cnt_q;
    logic [TO_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compared before the increment: the flag marks the cycle in which the
    // TIMEOUT-th consecutive low-PREADY ACCESS cycle is being observed.
    assign tc_o = (TIMEOUT != 0) && (cnt_q == TC_VAL);

endmodule

// File: rtl/apb3_master_bridge.sv
// APB3 master bridge: single-outstanding request/response port to APB3
// SETUP/ACCESS cycles on 16 one-hot slots, with slot-enable masking and an
// ACCESS-phase timeout. All outputs are registered.
// Ports:
//   PCLK, PRESETN                   : clock, asynchronous active-low reset
//   req_valid/req_ready             : request handshake (ready only in IDLE)
//   req_write/req_addr/req_wdata    : request direction, address, write data
//   resp_valid/resp_rdata/resp_err  : one-cycle response pulse and payload
//   PADDR/PWRITE/PWDATA/PSELS/PENABLE : APB request side
//   PRDATA/PREADY/PSLVERR           : muxed APB completion from the slots
module apb3_master_bridge
    import apb3_pkg::*;
#(
    parameter int                   ADDR_WIDTH = 32,
    parameter int                   SLOT_LSB   = 24,
    parameter logic [NUM_SLOTS-1:0] SLOT_EN    = 16'hFFFF,
    parameter int                   TIMEOUT    = 255,
    parameter int                   TO_WIDTH   = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    output logic [NUM_SLOTS-1:0]  PSELS,
    output logic                  PENABLE,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_state_e state_q, state_d;

    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [31:0]           pwdata_q, pwdata_d;
    logic [NUM_SLOTS-1:0]  psels_q, psels_d;
    logic                  penable_q, penable_d;

    logic [SLOT_IDX_W-1:0] req_slot;
    logic                  slot_present;
    logic                  accept;
    logic                  to_tc;

    assign req_slot     = req_addr[SLOT_LSB +: SLOT_IDX_W];
    assign slot_present = SLOT_EN[req_slot];
    assign accept       = req_valid && req_ready_q;

    apb3_timeout_cnt #(
        .TIMEOUT  (TIMEOUT),
        .TO_WIDTH (TO_WIDTH)
    ) u_timeout (
        .clk_i  (PCLK),
        .rst_ni (PRESETN),
        .clr_i  (state_q == SETUP),
        .en_i   ((state_q == ACCESS) && !PREADY),
        .tc_o   (to_tc)
    );

    // State register
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = slot_present ? SETUP : RESP;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (PREADY || to_tc) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next-values; response payload and APB request fields hold by default.
    always_comb begin
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        psels_d      = psels_q;
        penable_d    = penable_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_wdata;
                    if (slot_present) begin
                        psels_d = slot_onehot(req_slot);
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
            end
            ACCESS: begin
                // PREADY is checked first so a completion on the timeout
                // boundary is reported as a normal transfer.
                if (PREADY) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = PSLVERR;
                    resp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
                    psels_d      = '0;
                    penable_d    = 1'b0;
                end else if (to_tc) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                    psels_d      = '0;
                    penable_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            psels_q      <= '0;
            penable_q    <= 1'b0;
        end else begin
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            psels_q      <= psels_d;
            penable_q    <= penable_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign PADDR      = paddr_q;
    assign PWRITE     = pwrite_q;
    assign PWDATA     = pwdata_q;
    assign PSELS      = psels_q;
    assign PENABLE    = penable_q;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Directed bench for apb3_master_bridge (TIMEOUT=4, slots 0-7 and 15 present).
module tb_apb3_master_bridge;

    localparam int NEVER = 1000;

    logic        PCLK;
    logic        PRESETN;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [15:0] PSELS;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;

    apb3_master_bridge #(
        .ADDR_WIDTH (32),
        .SLOT_LSB   (24),
        .SLOT_EN    (16'h80FF),
        .TIMEOUT    (4),
        .TO_WIDTH   (8)
    ) dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .PADDR      (PADDR),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PSELS      (PSELS),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;      // low-PREADY ACCESS cycles before ready
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;    // acceptance edge to resp_valid, in cycles
        int          exp_acc;    // number of ACCESS cycles
        logic [15:0] exp_psels;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  k;
        int  acc;
        int  psel_cyc;
        int  lat;
        bit  stable;
        bit  oh_ok;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge PCLK);
            k++;
        end
        chk({v.name, " req_ready before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        PRDATA    = v.prdata;
        PSLVERR   = v.slverr;
        PREADY    = 1'b0;
        @(negedge PCLK);
        // Keep a conflicting request asserted; it must not disturb the transfer.
        req_write = ~v.wr;
        req_addr  = 32'h0100_0000;
        req_wdata = ~v.wdata;
        acc = 0; psel_cyc = 0; lat = -1; stable = 1'b1; oh_ok = 1'b1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            if (PSELS != 16'h0) begin
                psel_cyc++;
                if (PSELS != v.exp_psels) oh_ok = 1'b0;
                if (PADDR != v.addr || PWRITE != v.wr || PWDATA != v.wdata) stable = 1'b0;
            end
            if (PENABLE) begin
                acc++;
                if (PSELS == 16'h0) oh_ok = 1'b0;
            end
            PREADY = PENABLE && (acc == v.waits + 1);
            if (resp_valid) lat = c;
            else @(negedge PCLK);
        end
        req_valid = 1'b0;
        PREADY    = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL %s resp_valid: none within 40 cycles, expected at %0d", v.name, v.exp_lat);
        end else begin
            chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
            chk({v.name, " access cycles"}, 32'(acc), 32'(v.exp_acc));
            chk({v.name, " psel cycles"}, 32'(psel_cyc), 32'((v.exp_acc > 0) ? v.exp_acc + 1 : 0));
            chk({v.name, " psel onehot"}, 32'(oh_ok), 32'd1);
            chk({v.name, " bus stable"}, 32'(stable), 32'd1);
            chk({v.name, " resp_rdata"}, resp_rdata, v.exp_rdata);
            chk({v.name, " resp_err"}, 32'(resp_err), 32'(v.exp_err));
            chk({v.name, " psels in resp"}, 32'(PSELS), 32'd0);
            @(negedge PCLK);
            chk({v.name, " resp pulse"}, 32'(resp_valid), 32'd0);
            chk({v.name, " ready after"}, 32'(req_ready), 32'd1);
            chk({v.name, " rdata hold"}, resp_rdata, v.exp_rdata);
            chk({v.name, " paddr hold"}, PADDR, v.addr);
            chk({v.name, " pwdata hold"}, PWDATA, v.wdata);
        end
    endtask

    initial begin
        bit quiet;
        // name, wr, addr, wdata, waits, prdata, slverr, exp_rdata, exp_err, lat, acc, psels
        vecs[0] = '{"rd_s2_w0",   1'b0, 32'h0200_0010, 32'h0,         0,     32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 3, 1, 16'h0004};
        vecs[1] = '{"wr_s15_w3",  1'b1, 32'h0F00_0000, 32'h1234_5678, 3,     32'hAAAA_5555, 1'b0, 32'h0,         1'b0, 6, 4, 16'h8000};
        vecs[2] = '{"rd_s5_err",  1'b0, 32'h0500_0004, 32'h0,         0,     32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1, 3, 1, 16'h0020};
        vecs[3] = '{"rd_s3_to",   1'b0, 32'h0300_0008, 32'h0,         NEVER, 32'h5555_AAAA, 1'b0, 32'h0,         1'b1, 6, 4, 16'h0008};
        vecs[4] = '{"rd_s4_tb_e", 1'b0, 32'h0400_0000, 32'h0,         3,     32'h1357_9BDF, 1'b1, 32'h0,         1'b1, 6, 4, 16'h0010};
        vecs[5] = '{"rd_s6_tb",   1'b0, 32'h06AB_CDE0, 32'h0,         3,     32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 6, 4, 16'h0040};
        vecs[6] = '{"rd_s9_dis",  1'b0, 32'h0900_0000, 32'h0,         0,     32'h7777_7777, 1'b0, 32'h0,         1'b1, 1, 0, 16'h0000};
        vecs[7] = '{"wr_s0_w1",   1'b1, 32'h0000_0100, 32'hCAFE_0001, 1,     32'h1111_1111, 1'b0, 32'h0,         1'b0, 4, 2, 16'h0001};
        vecs[8] = '{"rd_s7_w2",   1'b0, 32'h0700_0ffc, 32'h0,         2,     32'h8000_0001, 1'b0, 32'h8000_0001, 1'b0, 5, 3, 16'h0080};

        PRESETN = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst resp_err", 32'(resp_err), 32'd0);
        chk("rst PADDR", PADDR, 32'd0);
        chk("rst PWRITE", 32'(PWRITE), 32'd0);
        chk("rst PWDATA", PWDATA, 32'd0);
        chk("rst PSELS", 32'(PSELS), 32'd0);
        chk("rst PENABLE", 32'(PENABLE), 32'd0);
        PRESETN = 1'b1;
        @(negedge PCLK);
        chk("ready after reset", 32'(req_ready), 32'd1);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset during the ACCESS phase of a slot-3 read whose slave never answers.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0300_0040; req_wdata = '0;
        PREADY = 1'b0; PSLVERR = 1'b0;
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        chk("mid-rst in access PENABLE", 32'(PENABLE), 32'd1);
        chk("mid-rst in access PSELS", 32'(PSELS), 32'h0008);
        #2 PRESETN = 1'b0;
        #1;
        chk("mid-rst PSELS", 32'(PSELS), 32'd0);
        chk("mid-rst PENABLE", 32'(PENABLE), 32'd0);
        chk("mid-rst PADDR", PADDR, 32'd0);
        chk("mid-rst req_ready", 32'(req_ready), 32'd0);
        quiet = 1'b1;
        repeat (3) begin
            @(negedge PCLK);
            if (resp_valid || PSELS != 16'h0) quiet = 1'b0;
        end
        PRESETN = 1'b1;
        repeat (2) begin
            @(negedge PCLK);
            if (resp_valid || PSELS != 16'h0) quiet = 1'b0;
        end
        chk("mid-rst no response", 32'(quiet), 32'd1);
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
